// File: rtl/rv32_decode_stage.sv
// Registered RV32I(+M) decode stage with a 2-entry skid buffer between fetch and execute.
// Entry 0 drives the outputs; entry 1 catches one instruction accepted while entry 0 is stalled.
module rv32_decode_stage #(
    parameter int unsigned PC_W     = 32,
    parameter bit          ENABLE_M = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_instr_i,
    input  logic [PC_W-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [PC_W-1:0] out_pc_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [2:0]      funct3_o,
    output logic [31:0]     imm_o,
    output logic [3:0]      alu_op_o,
    output logic            alu_src_o,
    output logic            md_en_o,
    output logic [2:0]      md_op_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            mem_to_reg_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            jalr_o,
    output logic            auipc_o,
    output logic            illegal_o
);
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluOr = 4'd2, AluXor = 4'd3;
    localparam logic [3:0] AluAnd = 4'd4, AluSra = 4'd5, AluSrl = 4'd6, AluSll = 4'd7;
    localparam logic [3:0] AluSlt = 4'd8, AluSltu = 4'd9, AluPassB = 4'd15;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [31:0]     imm;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            md_en;
        logic [2:0]      md_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            auipc;
        logic            illegal;
    } bundle_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_of = alt ? AluSub : AluAdd;
            3'b001:  alu_of = AluSll;
            3'b010:  alu_of = AluSlt;
            3'b011:  alu_of = AluSltu;
            3'b100:  alu_of = AluXor;
            3'b101:  alu_of = alt ? AluSra : AluSrl;
            3'b110:  alu_of = AluOr;
            default: alu_of = AluAnd;
        endcase
    endfunction

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    bundle_t     dec;

    assign opcode = in_instr_i[6:0];
    assign f3     = in_instr_i[14:12];
    assign f7     = in_instr_i[31:25];
    assign imm_i  = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
    assign imm_s  = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
    assign imm_b  = {{19{in_instr_i[31]}}, in_instr_i[31], in_instr_i[7], in_instr_i[30:25],
                     in_instr_i[11:8], 1'b0};
    assign imm_u  = {in_instr_i[31:12], 12'b0};
    assign imm_j  = {{11{in_instr_i[31]}}, in_instr_i[31], in_instr_i[19:12], in_instr_i[20],
                     in_instr_i[30:21], 1'b0};

    always_comb begin
        dec        = '0;
        legal      = 1'b1;
        dec.pc     = in_pc_i;
        dec.rd     = in_instr_i[11:7];
        dec.rs1    = in_instr_i[19:15];
        dec.rs2    = in_instr_i[24:20];
        dec.funct3 = f3;
        case (opcode)
            OpLui: begin
                dec.imm = imm_u; dec.alu_op = AluPassB; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
            end
            OpAuipc: begin
                dec.imm = imm_u; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.auipc = 1'b1;
            end
            OpJal: begin
                dec.imm = imm_j; dec.jump = 1'b1; dec.reg_write = 1'b1;
            end
            OpJalr: begin
                dec.imm = imm_i; dec.alu_src = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
                dec.reg_write = 1'b1;
                legal = (f3 == 3'b000);
            end
            OpBranch: begin
                dec.imm = imm_b; dec.alu_op = AluSub; dec.branch = 1'b1;
                legal = (f3[2:1] != 2'b01);
            end
            OpLoad: begin
                dec.imm = imm_i; dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1;
                dec.reg_write = 1'b1;
                legal = !((f3 == 3'b011) || (f3[2:1] == 2'b11));
            end
            OpStore: begin
                dec.imm = imm_s; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
                legal = !f3[2] && (f3 != 3'b011);
            end
            OpImm: begin
                dec.imm = imm_i; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = alu_of(f3, (f3 == 3'b101) && in_instr_i[30]);
                if (f3 == 3'b001) legal = (f7 == 7'b0000000);
                if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            end
            OpReg: begin
                dec.reg_write = 1'b1;
                if (f7 == 7'b0000000) begin
                    dec.alu_op = alu_of(f3, 1'b0);
                end else if (f7 == 7'b0100000) begin
                    dec.alu_op = alu_of(f3, 1'b1);
                    legal      = (f3 == 3'b000) || (f3 == 3'b101);
                end else if ((f7 == 7'b0000001) && ENABLE_M) begin
                    dec.md_en = 1'b1;
                    dec.md_op = f3;
                end else begin
                    legal = 1'b0;
                end
            end
            OpFence, OpSystem: dec.imm = imm_i;
            default: legal = 1'b0;
        endcase
        // Illegal bundles still flow in order but must not cause any side effect downstream
        if (!legal) begin
            dec.alu_op     = AluAdd;
            dec.alu_src    = 1'b0;
            dec.md_en      = 1'b0;
            dec.md_op      = 3'b000;
            dec.reg_write  = 1'b0;
            dec.mem_read   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.branch     = 1'b0;
            dec.jump       = 1'b0;
            dec.jalr       = 1'b0;
            dec.auipc      = 1'b0;
            dec.illegal    = 1'b1;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    end

    bundle_t e0_q, e0_d, e1_q, e1_d;
    logic    v0_q, v0_d, v1_q, v1_d;
    logic    fire_in, fire_out;

    assign in_ready_o = !v1_q && !rst_i;
    assign fire_in    = in_valid_i && in_ready_o && !flush_i;
    assign fire_out   = v0_q && out_ready_i;

    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        if (flush_i) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else if (fire_out) begin
            // fire_in cannot coincide with a full entry 1 since in_ready is low then
            if (v1_q) begin
                e0_d = e1_q;
                v1_d = 1'b0;
            end else if (fire_in) begin
                e0_d = dec;
            end else begin
                v0_d = 1'b0;
            end
        end else if (fire_in) begin
            if (v0_q) begin
                e1_d = dec;
                v1_d = 1'b1;
            end else begin
                e0_d = dec;
                v0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e0_q <= '0;
            e1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

    assign out_valid_o  = v0_q;
    assign out_pc_o     = e0_q.pc;
    assign rd_o         = e0_q.rd;
    assign rs1_o        = e0_q.rs1;
    assign rs2_o        = e0_q.rs2;
    assign funct3_o     = e0_q.funct3;
    assign imm_o        = e0_q.imm;
    assign alu_op_o     = e0_q.alu_op;
    assign alu_src_o    = e0_q.alu_src;
    assign md_en_o      = e0_q.md_en;
    assign md_op_o      = e0_q.md_op;
    assign reg_write_o  = e0_q.reg_write;
    assign mem_read_o   = e0_q.mem_read;
    assign mem_write_o  = e0_q.mem_write;
    assign mem_to_reg_o = e0_q.mem_to_reg;
    assign branch_o     = e0_q.branch;
    assign jump_o       = e0_q.jump;
    assign jalr_o       = e0_q.jalr;
    assign auipc_o      = e0_q.auipc;
    assign illegal_o    = e0_q.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: two instances (ENABLE_M=0/1) share stimulus and are checked
// against a queue-based occupancy model and an arithmetic decode reference.
module tb_rv32_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [13:0] ctl;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;

    logic        o_valid [2];
    logic        o_ready [2];
    logic [31:0] o_pc [2];
    logic [31:0] o_imm [2];
    logic [4:0]  o_rd [2];
    logic [4:0]  o_rs1 [2];
    logic [4:0]  o_rs2 [2];
    logic [2:0]  o_f3 [2];
    logic [2:0]  o_mdop [2];
    logic [3:0]  o_alu [2];
    logic        o_src [2], o_mde [2], o_rw [2], o_mr [2], o_mw [2], o_m2r [2];
    logic        o_br [2], o_jp [2], o_jr [2], o_au [2], o_ill [2];
    exp_t        obs [2];

    int total = 0;
    int bad = 0;
    int n_seen = 0;
    txn_t q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rv32_decode_stage #(
            .PC_W     (32),
            .ENABLE_M (g == 1)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .flush_i      (flush),
            .in_valid_i   (in_valid),
            .in_ready_o   (o_ready[g]),
            .in_instr_i   (in_instr),
            .in_pc_i      (in_pc),
            .out_valid_o  (o_valid[g]),
            .out_ready_i  (out_ready),
            .out_pc_o     (o_pc[g]),
            .rd_o         (o_rd[g]),
            .rs1_o        (o_rs1[g]),
            .rs2_o        (o_rs2[g]),
            .funct3_o     (o_f3[g]),
            .imm_o        (o_imm[g]),
            .alu_op_o     (o_alu[g]),
            .alu_src_o    (o_src[g]),
            .md_en_o      (o_mde[g]),
            .md_op_o      (o_mdop[g]),
            .reg_write_o  (o_rw[g]),
            .mem_read_o   (o_mr[g]),
            .mem_write_o  (o_mw[g]),
            .mem_to_reg_o (o_m2r[g]),
            .branch_o     (o_br[g]),
            .jump_o       (o_jp[g]),
            .jalr_o       (o_jr[g]),
            .auipc_o      (o_au[g]),
            .illegal_o    (o_ill[g])
        );
        assign obs[g] = {o_pc[g], o_rd[g], o_rs1[g], o_rs2[g], o_f3[g], o_imm[g], o_alu[g],
                         o_src[g], o_mde[g], o_mdop[g], o_rw[g], o_mr[g], o_mw[g], o_m2r[g],
                         o_br[g], o_jp[g], o_jr[g], o_au[g], o_ill[g]};
    end

    // Reference decoder: immediates by arithmetic shifts/masks, ALU ops from a funct3 table
    function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] pc, input bit m);
        exp_t              e;
        logic signed [31:0] s;
        logic [31:0]       imm, ii, is, ib, iu, ij;
        logic [3:0]        tab [8];
        logic [3:0]        alu;
        logic [2:0]        f3, mdop;
        logic [6:0]        f7;
        logic ok, src, mde, rw, mr, mw, m2r, br, jp, jr, au;
        tab = '{4'd0, 4'd7, 4'd8, 4'd9, 4'd3, 4'd6, 4'd2, 4'd4};
        s  = $signed(i);
        f3 = i[14:12];
        f7 = i[31:25];
        ii = 32'(s >>> 20);
        is = (32'(s >>> 20) & 32'hFFFF_FFE0) | 32'(i[11:7]);
        ib = (32'(s >>> 31) & 32'hFFFF_F000) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
             | (32'(i[11:8]) << 1);
        iu = i & 32'hFFFF_F000;
        ij = (32'(s >>> 31) & 32'hFFF0_0000) | (i & 32'h000F_F000) | (32'(i[20]) << 11)
             | (32'(i[30:21]) << 1);
        ok = 1'b1; imm = '0; alu = '0; mdop = '0;
        {src, mde, rw, mr, mw, m2r, br, jp, jr, au} = '0;
        case (i[6:0])
            7'h37: begin imm = iu; alu = 4'd15; src = 1; rw = 1; end
            7'h17: begin imm = iu; src = 1; rw = 1; au = 1; end
            7'h6F: begin imm = ij; jp = 1; rw = 1; end
            7'h67: begin imm = ii; src = 1; jp = 1; jr = 1; rw = 1; ok = (f3 == 0); end
            7'h63: begin imm = ib; alu = 4'd1; br = 1; ok = (f3 != 2) && (f3 != 3); end
            7'h03: begin
                imm = ii; src = 1; mr = 1; m2r = 1; rw = 1;
                ok = (f3 != 3) && (f3 != 6) && (f3 != 7);
            end
            7'h23: begin imm = is; src = 1; mw = 1; ok = (f3 <= 2); end
            7'h13: begin
                imm = ii; src = 1; rw = 1;
                alu = (f3 == 5 && i[30]) ? 4'd5 : tab[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
            end
            7'h33: begin
                rw = 1;
                if (f7 == 0) alu = tab[f3];
                else if (f7 == 7'h20) begin
                    ok  = (f3 == 0) || (f3 == 5);
                    alu = (f3 == 0) ? 4'd1 : 4'd5;
                end else if (f7 == 7'h01) begin
                    ok = m; mde = 1; mdop = f3;
                end else ok = 0;
            end
            7'h0F, 7'h73: imm = ii;
            default: ok = 0;
        endcase
        if (!ok) begin
            {src, mde, rw, mr, mw, m2r, br, jp, jr, au} = '0;
            alu = '0; mdop = '0;
        end
        if (i[11:7] == 0) rw = 0;
        e.pc  = pc;
        e.rd  = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.f3  = f3;
        e.imm = imm;
        e.alu = alu;
        e.ctl = {src, mde, mdop, rw, mr, mw, m2r, br, jp, jr, au, !ok};
        return e;
    endfunction

    task automatic chk(input string tag, input int g, input logic [31:0] o, input logic [31:0] x);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, g, o, x);
        end
    endtask

    task automatic chk_bundle(input int g, input exp_t e);
        chk("pc", g, obs[g].pc, e.pc);
        chk("regs", g, 32'({obs[g].rd, obs[g].rs1, obs[g].rs2, obs[g].f3}),
            32'({e.rd, e.rs1, e.rs2, e.f3}));
        chk("imm", g, obs[g].imm, e.imm);
        chk("alu_op", g, 32'(obs[g].alu), 32'(e.alu));
        chk("ctl", g, 32'(obs[g].ctl), 32'(e.ctl));
    endtask

    // Check outputs against the model, then advance the model and the clock together
    task automatic step();
        bit push, pop;
        for (int g = 0; g < 2; g++) begin
            chk("out_valid", g, 32'(o_valid[g]), 32'(q.size() > 0));
            chk("in_ready", g, 32'(o_ready[g]), 32'(q.size() < 2));
            if (q.size() > 0) chk_bundle(g, ref_dec(q[0].instr, q[0].pc, g == 1));
        end
        if (o_valid[0] === 1'b1 && out_ready) n_seen++;
        if (flush) begin
            q.delete();
        end else begin
            push = in_valid && (q.size() < 2);
            pop  = (q.size() > 0) && out_ready;
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{instr: in_instr, pc: in_pc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_state();
        for (int g = 0; g < 2; g++) begin
            chk("rst_out_valid", g, 32'(o_valid[g]), 32'd0);
            chk("rst_in_ready", g, 32'(o_ready[g]), 32'd0);
            chk_bundle(g, '0);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] w;
        int          r;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom;
        r = int'($urandom_range(0, 12));
        if (r < 11) w[6:0] = ops[r];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 0, 32'(o_ready[0]), 32'd1);

        // addi x5,x1,-1
        out_ready = 1'b1;
        send(32'hFFF08293, 32'h100);
        chk("addi_rd", 0, 32'(o_rd[0]), 32'd5);
        chk("addi_rs1", 0, 32'(o_rs1[0]), 32'd1);
        chk("addi_imm", 0, o_imm[0], 32'hFFFF_FFFF);
        chk("addi_alu", 0, 32'(o_alu[0]), 32'd0);
        chk("addi_src", 0, 32'(o_src[0]), 32'd1);
        chk("addi_rw", 0, 32'(o_rw[0]), 32'd1);
        // beq x1,x2,-4
        send(32'hFE208EE3, 32'h104);
        chk("beq_imm", 0, o_imm[0], 32'hFFFF_FFFC);
        chk("beq_branch", 0, 32'(o_br[0]), 32'd1);
        chk("beq_alu", 0, 32'(o_alu[0]), 32'd1);
        chk("beq_rw", 0, 32'(o_rw[0]), 32'd0);
        // jal x1,+2048
        send(32'h001000EF, 32'h108);
        chk("jal_imm", 0, o_imm[0], 32'h0000_0800);
        chk("jal_jump", 0, 32'(o_jp[0]), 32'd1);
        // mul x0,x1,x2 on both M configurations
        send(32'h02208033, 32'h10C);
        chk("mul_m0_ill", 0, 32'(o_ill[0]), 32'd1);
        chk("mul_m0_rw", 0, 32'(o_rw[0]), 32'd0);
        chk("mul_m1_mde", 1, 32'(o_mde[1]), 32'd1);
        chk("mul_m1_mdop", 1, 32'(o_mdop[1]), 32'd0);
        chk("mul_m1_ill", 1, 32'(o_ill[1]), 32'd0);
        send(32'h00000000, 32'h110);
        chk("zero_ill", 0, 32'(o_ill[0]), 32'd1);
        send(32'h00100013, 32'h114);
        chk("addi_x0_rw", 0, 32'(o_rw[0]), 32'd0);
        chk("addi_x0_ill", 0, 32'(o_ill[0]), 32'd0);
        step();

        // Stall after first of three: in_ready drops with two held, then all drain in order
        base = n_seen;
        send(32'h00500093, 32'h200);
        out_ready = 1'b0;
        send(32'h00600113, 32'h204);
        in_valid = 1'b1; in_instr = 32'h00700193; in_pc = 32'h208;
        repeat (3) step();
        chk("stall_in_ready", 0, 32'(o_ready[0]), 32'd0);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("stream_count", 0, 32'(n_seen - base), 32'd3);

        // Flush with both entries full and a third on the input
        base = n_seen;
        out_ready = 1'b0;
        send(32'h00800213, 32'h300);
        send(32'h00900293, 32'h304);
        in_valid = 1'b1; in_instr = 32'h00A00313; in_pc = 32'h308; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 0, 32'(o_valid[0]), 32'd0);
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush_count", 0, 32'(n_seen - base), 32'd0);

        // Reset mid-stream discards buffered bundles
        out_ready = 1'b0;
        send(32'h00B00393, 32'h400);
        send(32'h00C00413, 32'h404);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state();
        rst = 1'b0; in_valid = 1'b0;
        q.delete();
        #1;
        step();

        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
